ascii_frame_ctrl: RTL and testbench

ASCII_FRAME_CTRL -- requirements
Module: ascii_frame_ctrl

---
 rtl/ascii_pkg.sv | 23 ++
 rtl/ascii_frame_ctrl_if.sv | 21 ++
 rtl/ascii.sv | 34 +++
 rtl/ascii_frame_ctrl.sv | 165 ++++++++++++++++
 tb/tb_ascii_frame_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/ascii_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ascii_pkg
// Purpose  : Shared constants and FSM encoding for the ASCII frame controller.
//            Holds the frame geometry, the NUL terminator value and the
//            controller state type.
// Revision : 1.0 - initial release
// ============================================================================
package ascii_pkg;

    localparam int          FRAME_BYTES = 24;
    localparam int          FRAME_W     = FRAME_BYTES * 8;   // 192 bits
    localparam logic [7:0]  NUL_BYTE    = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EVAL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage : ascii_pkg
`default_nettype wire

// File: rtl/ascii_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ascii_frame_ctrl_if
// Purpose  : Byte-stream handshake into the ASCII frame controller.
// Signals  : in_valid - producer has a byte on in_byte
//            in_byte  - ASCII byte, first byte of a frame first
//            in_ready - controller takes in_byte this cycle
// Modports : master (byte producer), slave (frame controller)
// Revision : 1.0 - initial release
// ============================================================================
interface ascii_frame_ctrl_if;

    logic       in_valid;
    logic [7:0] in_byte;
    logic       in_ready;

    modport master (output in_valid, output in_byte, input  in_ready);
    modport slave  (input  in_valid, input  in_byte, output in_ready);

endinterface : ascii_frame_ctrl_if
`default_nettype wire

// File: rtl/ascii.sv
`default_nettype none
// ============================================================================
// Module   : ascii
// Purpose  : Combinational frame decoder. Flags a frame that opens with the
//            greeting "Hello" and contains only printable ASCII or NUL bytes.
// Ports    : frame - FRAME_W-bit frame, first byte in the top byte lane
//            match - decode result
// Revision : 1.0 - initial release
// ============================================================================
module ascii
    import ascii_pkg::*;
(
    input  logic [FRAME_W-1:0] frame,
    output logic               match
);

    localparam logic [39:0] GREETING = 40'h48656C6C6F;

    logic       w_printable;
    logic [7:0] w_ch;

    always_comb begin
        w_printable = 1'b1;
        w_ch        = '0;
        for (int i = 0; i < FRAME_W / 8; i++) begin
            w_ch = frame[8*i +: 8];
            if (!((w_ch == NUL_BYTE) || ((w_ch >= 8'h20) && (w_ch <= 8'h7E))))
                w_printable = 1'b0;
        end
        match = w_printable && (frame[FRAME_W-1 -: 40] == GREETING);
    end

endmodule : ascii
`default_nettype wire

// File: rtl/ascii_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ascii_frame_ctrl
// Purpose  : Assembles an ASCII byte stream into a fixed-size frame, keeps a
//            running mod-256 checksum, and evaluates the finished frame with
//            the ascii decoder. A frame ends on a NUL byte or on its last byte.
// Ports    : clk, rst_n (async, active-low), clear (sync abort)
//            src        - byte stream handshake (slave side)
//            frame_data - assembled frame, first byte in the top byte lane
//            match      - registered decoder result of the last frame
//            checksum   - mod-256 sum of accepted bytes
//            byte_count - bytes accepted in the current frame
//            busy       - high while LOAD, EVAL or DONE
//            done       - one-cycle pulse once match/checksum are final
// Revision : 1.0 - initial release
// ============================================================================
module ascii_frame_ctrl #(
    parameter int FRAME_BYTES = ascii_pkg::FRAME_BYTES
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear,
    ascii_frame_ctrl_if.slave                src,
    output logic [FRAME_BYTES*8-1:0]         frame_data,
    output logic                             match,
    output logic [7:0]                       checksum,
    output logic [$clog2(FRAME_BYTES+1)-1:0] byte_count,
    output logic                             busy,
    output logic                             done
);

    import ascii_pkg::*;

    localparam int                FW       = FRAME_BYTES * 8;
    localparam int                CNT_W    = $clog2(FRAME_BYTES + 1);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(FRAME_BYTES - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_alive;        // low until the first edge after reset
    logic [FW-1:0]      r_frame_data;
    logic               r_match;
    logic [7:0]         r_checksum;
    logic [CNT_W-1:0]   r_byte_count;

    logic               w_ready;
    logic               w_accept;
    logic               w_last;
    logic               w_busy;
    logic               w_done;
    logic               w_dec_match;
    logic [CNT_W-1:0]   w_idx;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_alive <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_alive <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next state and handshake/status outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        w_idx       = '0;

        case (r_state)
            ST_IDLE: w_ready = r_alive;
            ST_LOAD: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
            end
            ST_EVAL: begin
                w_busy      = 1'b1;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_busy      = 1'b1;
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (clear)
            w_ready = 1'b0;

        // In IDLE the count still shows the previous frame; the incoming
        // byte is always slot 0 of a new frame.
        w_idx    = (r_state == ST_IDLE) ? '0 : r_byte_count;
        w_accept = w_ready && src.in_valid;
        w_last   = (src.in_byte == NUL_BYTE) || (w_idx == LAST_IDX);

        if (w_accept)
            w_state_nxt = w_last ? ST_EVAL : ST_LOAD;

        if (clear) begin
            w_state_nxt = ST_IDLE;
            w_done      = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Frame datapath: byte placement, counter, checksum, decoder capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_data <= '0;
            r_match      <= 1'b0;
            r_checksum   <= 8'h00;
            r_byte_count <= '0;
        end else if (clear) begin
            r_frame_data <= '0;
            r_match      <= 1'b0;
            r_checksum   <= 8'h00;
            r_byte_count <= '0;
        end else begin
            if (w_accept && (r_state == ST_IDLE)) begin
                // First byte wipes the previous frame so unwritten slots
                // of a short frame read back as zero.
                r_frame_data <= {src.in_byte, {(FW-8){1'b0}}};
                r_checksum   <= src.in_byte;
                r_byte_count <= CNT_W'(1);
                r_match      <= 1'b0;
            end else if (w_accept) begin
                for (int i = 0; i < FRAME_BYTES; i++) begin
                    if (r_byte_count == CNT_W'(i))
                        r_frame_data[FW-1-8*i -: 8] <= src.in_byte;
                end
                r_checksum   <= r_checksum + src.in_byte;
                r_byte_count <= r_byte_count + CNT_W'(1);
            end

            if (r_state == ST_EVAL)
                r_match <= w_dec_match;
        end
    end

    ascii u_dec (
        .frame (r_frame_data),
        .match (w_dec_match)
    );

    assign src.in_ready = w_ready;
    assign frame_data   = r_frame_data;
    assign match        = r_match;
    assign checksum     = r_checksum;
    assign byte_count   = r_byte_count;
    assign busy         = w_busy;
    assign done         = w_done;

endmodule : ascii_frame_ctrl
`default_nettype wire

// File: tb/tb_ascii_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ascii_frame_ctrl
// Purpose  : Directed self-checking bench for ascii_frame_ctrl: full frame,
//            NUL-terminated frame, stalled frame, clear in IDLE/mid-frame/on
//            final byte, reset mid-frame and checksum wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ascii_frame_ctrl;

    logic         clk;
    logic         rst_n;
    logic         clear;
    logic [191:0] frame_data;
    logic         match;
    logic [7:0]   checksum;
    logic [4:0]   byte_count;
    logic         busy;
    logic         done;

    logic [191:0] ref_frame;
    logic         ref_match;
    logic [191:0] full;

    int tests    = 0;
    int fails    = 0;
    int done_cnt = 0;

    ascii_frame_ctrl_if bus ();

    ascii_frame_ctrl #(.FRAME_BYTES(24)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .src        (bus),
        .frame_data (frame_data),
        .match      (match),
        .checksum   (checksum),
        .byte_count (byte_count),
        .busy       (busy),
        .done       (done)
    );

    // Reference decoder fed with the expected frame.
    ascii u_ref (
        .frame (ref_frame),
        .match (ref_match)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) if (done) done_cnt++;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        guard = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        while (!bus.in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check("ready_timeout", bus.in_ready, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Called right after the terminating byte was taken.
    task automatic end_frame(input logic [191:0] ef, input logic [7:0] ecs,
                             input logic [4:0] ecnt, input logic emat);
        int d0;
        d0 = done_cnt;
        @(negedge clk);
        check("eval_done",  done, 0);
        check("eval_ready", bus.in_ready, 0);
        check("eval_busy",  busy, 1);
        @(negedge clk);
        check("done_pulse", done, 1);
        check("done_ready", bus.in_ready, 0);
        check("frame_data", frame_data, ef);
        check("checksum",   checksum, ecs);
        check("byte_count", byte_count, ecnt);
        check("match",      match, emat);
        ref_frame = ef;
        #1 check("match_ref", match, ref_match);
        @(negedge clk);
        check("idle_done",  done, 0);
        check("idle_busy",  busy, 0);
        check("idle_ready", bus.in_ready, 1);
        check("done_once",  done_cnt - d0, 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_frame"}, frame_data, 0);
        check({tag, "_cs"},    checksum, 0);
        check({tag, "_cnt"},   byte_count, 0);
        check({tag, "_match"}, match, 0);
        check({tag, "_busy"},  busy, 0);
    endtask

    initial begin
        int d;
        rst_n        = 1'b0;
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;
        ref_frame    = '0;
        full         = 192'h48656C6C6F20436865636B53756D2050726F6A6563742100;

        // Reset state, before any clock edge
        #1;
        check_zero("rst");
        check("rst_done",  done, 0);
        check("rst_ready", bus.in_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("ready_pre_edge", bus.in_ready, 0);
        @(negedge clk);
        check("ready_post_edge", bus.in_ready, 1);

        // Full 24-byte frame, back to back
        for (int i = 0; i < 24; i++) send_byte(full[191-8*i -: 8], 0);
        end_frame(full, 8'h3F, 5'd24, 1'b1);

        // IDLE holds the last frame
        repeat (3) @(negedge clk);
        check("hold_frame", frame_data, full);
        check("hold_cs",    checksum, 8'h3F);
        check("hold_cnt",   byte_count, 5'd24);
        check("hold_match", match, 1);

        // NUL-terminated frame; first byte wipes previous state
        send_byte(8'h41, 0);
        check("first_match", match, 0);
        check("first_cnt",   byte_count, 5'd1);
        check("first_cs",    checksum, 8'h41);
        check("first_frame", frame_data, {8'h41, 184'h0});
        check("first_busy",  busy, 1);
        send_byte(8'h42, 0);
        send_byte(8'h00, 0);
        end_frame({24'h414200, 168'h0}, 8'h83, 5'd3, 1'b0);

        // Full frame with random stalls
        d = done_cnt;
        for (int i = 0; i < 24; i++) send_byte(full[191-8*i -: 8], $urandom_range(0, 3));
        end_frame(full, 8'h3F, 5'd24, 1'b1);
        check("stall_done_total", done_cnt - d, 1);

        // Clear in IDLE wipes a held matching frame
        @(negedge clk);
        clear = 1'b1;
        #1 check("clear_ready", bus.in_ready, 0);
        @(negedge clk);
        clear = 1'b0;
        check_zero("clr_idle");

        // Clear after 10 bytes, with a byte offered alongside
        for (int i = 0; i < 10; i++) send_byte(full[191-8*i -: 8], 0);
        @(negedge clk);
        clear        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_byte  = full[191-80 -: 8];
        #1 check("clear_mid_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        check_zero("clr_mid");
        send_byte(8'h7A, 0);
        send_byte(8'h00, 0);
        end_frame({16'h7A00, 176'h0}, 8'h7A, 5'd2, 1'b0);

        // Clear coinciding with the would-be final byte
        send_byte(8'h41, 0);
        d = done_cnt;
        @(negedge clk);
        clear        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'h00;
        @(posedge clk);
        #1;
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("clr_final_nodone", done_cnt - d, 0);
        check_zero("clr_final");

        // Reset after 12 bytes
        d = done_cnt;
        for (int i = 0; i < 12; i++) send_byte(full[191-8*i -: 8], 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        check("rst_mid_done",  done, 0);
        check("rst_mid_ready", bus.in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_hold_ready", bus.in_ready, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rel_ready", bus.in_ready, 1);
        check("rst_nodone",    done_cnt - d, 0);

        // Checksum wrap-around
        send_byte(8'hFF, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        end_frame({32'hFFFF0200, 160'h0}, 8'h00, 5'd4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_ascii_frame_ctrl
`default_nettype wire
